// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, halt.
// Optional macro MEM_WAIT_EN stretches memory cycles until Mem_ready.
module control_sequencer #(
  parameter int OPW = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Mem_ready,
  output logic           Run,
  output logic [OPW-1:0] opcode,
  output logic           Read, Write, IncPC,
  output logic           Gra, Grb, Grc, Rin, Rout, BAout,
  output logic           HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
  output logic           Inportin, Outportin, CONin,
  output logic           HIout, LOout, Yout, Zhighout, Zlowout, PCout,
  output logic           MARout, MDRout, Inportout, Outportout, Cout,
  output logic [3:0]     o_dbg_state
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_RLO  = 5'b00011;
  localparam logic [OPW-1:0] OP_RHI  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  state_t         r_state;
  logic [OPW-1:0] w_op;
  logic           w_rtype, w_addi, w_ldi, w_ld, w_st, w_br, w_jr, w_halt;
  logic           w_long, w_stall, w_unused;

  assign w_op    = IR[31 -: OPW];
  assign w_rtype = (w_op >= OP_RLO) && (w_op <= OP_RHI);
  assign w_addi  = (w_op == OP_ADDI);
  assign w_ldi   = (w_op == OP_LDI);
  assign w_ld    = (w_op == OP_LD);
  assign w_st    = (w_op == OP_ST);
  assign w_br    = (w_op == OP_BR);
  assign w_jr    = (w_op == OP_JR);
  assign w_halt  = (w_op == OP_HALT);
  // Opcodes that continue past T3; everything else (nop, unlisted, jr) ends there.
  assign w_long  = w_rtype | w_addi | w_ldi | w_ld | w_st | w_br;
  assign o_dbg_state = r_state;

`ifdef MEM_WAIT_EN
  assign w_stall  = !Mem_ready && ((r_state == T1) ||
                                   (r_state == T6 && w_ld) ||
                                   (r_state == T7 && w_st));
  assign w_unused = ^IR[31-OPW:0];
`else
  assign w_stall  = 1'b0;
  assign w_unused = ^{IR[31-OPW:0], Mem_ready};
`endif

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= RST;
    end else begin
      case (r_state)
        RST:  r_state <= T0;
        T0:   r_state <= T1;
        T1:   r_state <= w_stall ? T1 : T2;
        T2:   r_state <= T3;
        T3:   r_state <= w_halt ? HALT : (w_long ? T4 : T0);
        T4:   r_state <= T5;
        T5:   r_state <= (w_ld | w_st | w_br) ? T6 : T0;
        T6:   r_state <= w_stall ? T6 : (w_br ? T0 : T7);
        T7:   r_state <= w_stall ? T7 : T0;
        HALT: r_state <= HALT;
        default: r_state <= RST;
      endcase
    end
  end

  always_comb begin
    Run = 1'b0; opcode = '0;
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Yin = 1'b0; Zin = 1'b0; PCin = 1'b0;
    IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Inportin = 1'b0;
    Outportin = 1'b0; CONin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Yout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MARout = 1'b0; MDRout = 1'b0; Inportout = 1'b0;
    Outportout = 1'b0; Cout = 1'b0;
    case (r_state)
      T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        Run = 1'b1;
        if (w_rtype || w_addi) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_ldi || w_ld || w_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (w_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end
      end
      T4: begin
        Run = 1'b1;
        if (w_rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = w_op;
        end else if (w_addi || w_ldi || w_ld || w_st) begin
          Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD;
        end else if (w_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      T5: begin
        Run = 1'b1;
        if (w_rtype || w_addi || w_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_ld || w_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (w_br) begin
          Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD;
        end
      end
      T6: begin
        Run = 1'b1;
        if (w_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (w_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (w_br && CON_FF) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      T7: begin
        Run = 1'b1;
        if (w_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
